// File: rtl/mp_pkg.sv
// Shared types for the multiprocessor memory arbiter.
// Core ids, arbiter states and round-robin pointer helper.
package mp_pkg;

  localparam int NCORES = 3;

  typedef logic [1:0] core_id_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    RESP
  } arb_state_t;

  function automatic core_id_t next_ptr(core_id_t p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational 3-way round-robin picker.
// Searches ptr, ptr+1, ptr+2 (mod 3) for the first requester.
module rr_pick
  import mp_pkg::*;
(
  input  logic [2:0] req,
  input  core_id_t   ptr,
  output logic       valid,
  output core_id_t   winner
);

  always_comb begin
    core_id_t c;
    c      = ptr;
    valid  = 1'b0;
    winner = ptr;
    for (int i = 0; i < NCORES; i++) begin
      if (!valid && req[c]) begin
        valid  = 1'b1;
        winner = c;
      end
      c = next_ptr(c);
    end
  end

endmodule

// File: rtl/mp_mem_arbiter.sv
// Round-robin sequencer sharing one single-port memory between three cores.
// One transaction in flight; exactly one response per grant.
module mp_mem_arbiter
  import mp_pkg::*;
#(
  parameter int AW      = 11,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      req,
  input  logic [2:0]      we,
  input  logic [3*AW-1:0] addr,
  input  logic [3*DW-1:0] wdata,
  output logic [2:0]      gnt,
  output logic [2:0]      rvalid,
  output logic [3*DW-1:0] rdata,
  output logic [2:0]      err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  localparam int CW = $clog2(TIMEOUT);

  arb_state_t    state;
  core_id_t      rr_ptr;
  core_id_t      owner;
  core_id_t      pick_id;
  logic          pick_valid;
  logic          pick_we;
  logic [AW-1:0] pick_addr;
  logic [DW-1:0] pick_wdata;
  logic [CW-1:0] cnt;

  rr_pick u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .valid  (pick_valid),
    .winner (pick_id)
  );

  always_comb begin
    pick_we    = we[0];
    pick_addr  = addr[AW-1:0];
    pick_wdata = wdata[DW-1:0];
    unique case (pick_id)
      2'd1: begin
        pick_we    = we[1];
        pick_addr  = addr[2*AW-1:AW];
        pick_wdata = wdata[2*DW-1:DW];
      end
      2'd2: begin
        pick_we    = we[2];
        pick_addr  = addr[3*AW-1:2*AW];
        pick_wdata = wdata[3*DW-1:2*DW];
      end
      default: ;
    endcase
  end

  function automatic logic [3*DW-1:0] place(core_id_t id, logic [DW-1:0] d);
    return {{(2*DW){1'b0}}, d} << (id * DW);
  endfunction

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      cnt       <= '0;
      gnt       <= '0;
      rvalid    <= '0;
      rdata     <= '0;
      err       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      gnt <= '0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            owner     <= pick_id;
            gnt       <= 3'b001 << pick_id;
            mem_req   <= 1'b1;
            mem_we    <= pick_we;
            mem_addr  <= pick_addr;
            mem_wdata <= pick_wdata;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              rvalid <= 3'b001 << owner;
              rdata  <= place(owner, mem_wdata);
              state  <= RESP;
            end else begin
              cnt   <= '0;
              state <= WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          // read data arriving on the last counted cycle beats the timeout
          if (mem_rvalid) begin
            rvalid <= 3'b001 << owner;
            rdata  <= place(owner, mem_rdata);
            state  <= RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            rvalid <= 3'b001 << owner;
            err    <= 3'b001 << owner;
            rdata  <= '0;
            state  <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          rvalid <= '0;
          rdata  <= '0;
          err    <= '0;
          rr_ptr <= next_ptr(owner);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mp_mem_arbiter.sv
// Randomised bench for mp_mem_arbiter against a transaction-level model.
// Bench also plays the three cores and the memory.
module tb_mp_mem_arbiter;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2:0]      req;
  logic [2:0]      we;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]      gnt;
  logic [2:0]      rvalid;
  logic [3*DW-1:0] rdata;
  logic [2:0]      err;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_ready;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;
  logic            busy;

  always #5 clk = ~clk;

  mp_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .err        (err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // core agents
  bit            p_pend [3];
  logic          p_we   [3];
  logic [AW-1:0] p_addr [3];
  logic [DW-1:0] p_wd   [3];

  // memory contents and transaction model
  logic [DW-1:0] mem [2**AW];
  int            cyc = 0;
  bit            act, act_prev, issue, acc, resp_now;
  int            owner, last, resp_cyc, mv_cyc, acc_cyc;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd, rd_val, r_data;
  bit            r_err;
  logic [2:0]    req_prev;

  // knobs
  int req_pct, rdy_pct, lat, stray_pct, hold;
  bit wr_only;

  // DUT-side observations
  int dq[$];
  int dgc[$];
  int dut_acc, mreq_cnt;

  function automatic int winner(logic [2:0] r, int l);
    for (int k = 1; k <= 3; k++)
      if (r[(l + k) % 3]) return (l + k) % 3;
    return -1;
  endfunction

  task automatic step();
    bit g;
    int L;
    bit in_wait;
    logic [2:0]  eg, ev, ee;
    logic [23:0] ed;
    @(negedge clk);
    cyc++;
    resp_now = 1'b0;
    if (act && resp_cyc == cyc - 1) act = 1'b0;
    g = 1'b0;
    if (!act_prev && req_prev != 3'b000) begin
      g      = 1'b1;
      owner  = winner(req_prev, last);
      act    = 1'b1;
      issue  = 1'b1;
      acc    = 1'b0;
      m_we   = p_we[owner];
      m_addr = p_addr[owner];
      m_wd   = p_wd[owner];
    end
    eg = g ? 3'(1 << owner) : 3'b000;
    ev = 3'b000;
    ee = 3'b000;
    ed = 24'h0;
    if (act && resp_cyc == cyc) begin
      resp_now = 1'b1;
      ev   = 3'(1 << owner);
      ee   = r_err ? ev : 3'b000;
      ed   = 24'(r_data) << (8 * owner);
      last = owner;
    end
    check("gnt", 32'(gnt), 32'(eg));
    check("busy", 32'(busy), 32'(act));
    check("mem_req", 32'(mem_req), 32'(issue));
    if (issue)
      check("mem_fields", 32'({mem_we, mem_addr, mem_wdata}),
            32'({m_we, m_addr, m_wd}));
    check("rvalid", 32'(rvalid), 32'(ev));
    check("err", 32'(err), 32'(ee));
    check("rdata", 32'(rdata), 32'(ed));
    for (int i = 0; i < 3; i++)
      if (gnt[i]) begin
        dq.push_back(i);
        dgc.push_back(cyc);
      end
    if (mem_req) mreq_cnt++;

    mem_ready = 1'b0;
    if (issue) begin
      if (hold > 0) hold--;
      else mem_ready = ($urandom_range(99) < rdy_pct);
      if (mem_ready) begin
        issue   = 1'b0;
        acc     = 1'b1;
        acc_cyc = cyc;
        if (m_we) begin
          mem[m_addr] = m_wd;
          resp_cyc    = cyc + 1;
          r_data      = m_wd;
          r_err       = 1'b0;
        end else begin
          L = lat;
          if (L == -2) L = ($urandom_range(7) == 0) ? -1 : int'($urandom_range(19, 1));
          rd_val = mem[m_addr];
          mv_cyc = (L < 0) ? -100 : cyc + L;
          if (L >= 1 && L <= TO) begin
            resp_cyc = cyc + L + 1;
            r_data   = rd_val;
            r_err    = 1'b0;
          end else begin
            resp_cyc = cyc + TO + 1;
            r_data   = '0;
            r_err    = 1'b1;
          end
        end
      end
    end else begin
      mem_ready = 1'($urandom_range(1));
    end
    if (mem_req && mem_ready) dut_acc = cyc;
    in_wait = act && acc && !m_we && cyc > acc_cyc && cyc < resp_cyc;
    mem_rvalid = (cyc == mv_cyc) || (!in_wait && $urandom_range(99) < stray_pct);
    mem_rdata  = (cyc == mv_cyc) ? rd_val : DW'($urandom);

    if (g) p_pend[owner] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!p_pend[i] && $urandom_range(99) < req_pct) begin
        p_pend[i] = 1'b1;
        p_we[i]   = wr_only ? 1'b1 : 1'($urandom_range(1));
        p_addr[i] = AW'($urandom_range(15));
        p_wd[i]   = DW'($urandom);
      end
      req[i]             = p_pend[i];
      we[i]              = p_pend[i] ? p_we[i] : 1'($urandom_range(1));
      addr[i*AW +: AW]   = p_pend[i] ? p_addr[i] : AW'($urandom);
      wdata[i*DW +: DW]  = p_pend[i] ? p_wd[i] : DW'($urandom);
    end
    req_prev = req;
    act_prev = act;
  endtask

  task automatic post(int i, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
    p_pend[i] = 1'b1;
    p_we[i]   = w;
    p_addr[i] = a;
    p_wd[i]   = d;
  endtask

  task automatic model_clear();
    act = 0; act_prev = 0; issue = 0; acc = 0; last = 2;
    resp_cyc = -100; mv_cyc = -100; acc_cyc = -100; hold = 0;
    for (int i = 0; i < 3; i++) p_pend[i] = 1'b0;
    req = '0; req_prev = '0; we = '0; addr = '0; wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check("reset_ctl", 32'({gnt, rvalid, err, mem_req, mem_we, busy}), 32'd0);
    check("reset_data", 32'(rdata), 32'd0);
    check("reset_mem", 32'({mem_addr, mem_wdata}), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while ((act || act_prev || issue || req_prev != 0 ||
            p_pend[0] || p_pend[1] || p_pend[2]) && n < 200) begin
      step();
      n++;
    end
    step();
  endtask

  task automatic wait_resp();
    int n = 0;
    do begin
      step();
      n++;
    end while (!resp_now && n < 80);
  endtask

  int lats[3] = '{-1, 16, 17};

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    req_pct = 0; rdy_pct = 100; lat = -2; stray_pct = 0; wr_only = 0;
    dut_acc = 0; mreq_cnt = 0;
    do_reset();
    repeat (2) step();

    // single write, ready tied high
    post(1, 1'b1, 11'h005, 8'hA5);
    step();
    step();
    check("t1_gnt", 32'(gnt), 32'(3'b010));
    check("t1_mem", 32'({mem_req, mem_addr, mem_wdata}), 32'({1'b1, 11'h005, 8'hA5}));
    step();
    check("t1_rvalid", 32'(rvalid), 32'(3'b010));
    check("t1_rdata", 32'(rdata), 32'(24'h00A500));
    drain();

    // read with 3-cycle memory latency
    mem[11'h010] = 8'h3C;
    lat = 3;
    post(2, 1'b0, 11'h010, 8'h00);
    wait_resp();
    check("t2_rvalid", 32'(rvalid), 32'(3'b100));
    check("t2_rdata", 32'(rdata), 32'(24'h3C0000));
    check("t2_err", 32'(err), 32'd0);
    check("t2_lat", 32'(cyc - dut_acc), 32'd4);
    drain();

    // all cores requesting writes continuously from reset
    do_reset();
    req_pct = 100; wr_only = 1;
    dq.delete(); dgc.delete();
    repeat (20) step();
    req_pct = 0; wr_only = 0;
    for (int k = 0; k < 6; k++)
      check("t3_order", 32'(k < dq.size() ? dq[k] : -1), 32'(k % 3));
    for (int k = 1; k < 6; k++)
      check("t3_gap", 32'(k < dgc.size() ? dgc[k] - dgc[k-1] : -1), 32'd3);
    drain();

    // memory stalls ISSUE for 5 cycles
    hold = 5;
    mreq_cnt = 0;
    post(0, 1'b1, 11'h7FF, 8'h5A);
    wait_resp();
    check("t4_mreq_cycles", 32'(mreq_cnt), 32'd6);
    check("t4_rdata", 32'(rdata), 32'(24'h00005A));
    drain();

    // timeout, data on last wait cycle, data one cycle late
    for (int k = 0; k < 3; k++) begin
      lat = lats[k];
      mem[11'h020] = 8'h77;
      post(1, 1'b0, 11'h020, 8'h00);
      wait_resp();
      check("t5_rvalid", 32'(rvalid), 32'(3'b010));
      check("t5_err", 32'(err), 32'(lats[k] == 16 ? 3'b000 : 3'b010));
      check("t5_rdata", 32'(rdata), 32'(lats[k] == 16 ? 24'h007700 : 24'h0));
      check("t5_lat", 32'(cyc - dut_acc), 32'd17);
      drain();
    end
    post(2, 1'b1, 11'h030, 8'h11);
    wait_resp();
    check("t5_next", 32'({rvalid, err, rdata[23:16]}), 32'({3'b100, 3'b000, 8'h11}));
    drain();

    // reset in the middle of a read
    lat = -1;
    post(0, 1'b0, 11'h040, 8'h00);
    for (int n = 0; n < 40 && !(acc && cyc >= acc_cyc + 3); n++) step();
    #2 rst_n = 1'b0;
    #1;
    check("t6_ctl", 32'({gnt, rvalid, err, mem_req, mem_we, busy}), 32'd0);
    check("t6_rdata", 32'(rdata), 32'd0);
    check("t6_mem", 32'({mem_addr, mem_wdata}), 32'd0);
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lat = -2;
    stray_pct = 100;
    repeat (4) step();
    stray_pct = 0;
    post(0, 1'b1, 11'h001, 8'h01);
    post(1, 1'b1, 11'h002, 8'h02);
    post(2, 1'b1, 11'h003, 8'h03);
    dq.delete();
    step();
    step();
    check("t6_first", 32'(dq.size() > 0 ? dq[0] : -1), 32'd0);
    drain();

    // random traffic
    req_pct = 35; rdy_pct = 70; lat = -2; stray_pct = 10;
    repeat (3000) step();
    req_pct = 0; stray_pct = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mp_mem_arbiter.md
Name: mp_mem_arbiter

Overview:
Round-robin arbiter and sequencer that shares one single-port memory between the three generator cores of the multiprocessor top level. It replaces the free-running rotating grant and the stubbed echo response.
- Accepts one transaction at a time.
- Issues it to memory with a ready handshake.
- Waits for read data, with a timeout.
- Routes exactly one response (rvalid/rdata/err) back to the owning core.

Parameters:
AW, 11, address width
DW, 8, data width
TIMEOUT, 16, max cycles in WAIT_RD before an error response (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req  in  3  per-core request; held until gnt
we  in  3  per-core write enable (1=write, 0=read)
addr  in  3xAW  per-core address
wdata  in  3xDW  per-core write data
gnt  out  3  one-cycle one-hot grant pulse
rvalid  out  3  one-cycle one-hot response pulse
rdata  out  3xDW  per-core response data; 0 for any core whose rvalid=0
err  out  3  qualifies rvalid; 1 = read timed out
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_ready  in  1  memory accepts request when mem_req&&mem_ready
mem_rvalid  in  1  read data valid
mem_rdata  in  DW  read data
busy  out  1  1 whenever state != IDLE

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rst_n.
- Registered outputs: all outputs except busy are registered. busy decodes state.
- Reset values: every output is 0, state=IDLE, rr_ptr=0, timeout counter=0.

States:
- IDLE: if any req, pick winner by searching rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3). Capture owner, we, addr, wdata. Next cycle: gnt[owner]=1 for exactly one cycle, state ISSUE. If no req, stay in IDLE.
- ISSUE: mem_req=1 with captured fields.
  - Hold until mem_ready; fields must not change while waiting.
  - On acceptance, a write goes to RESP with resp_data=wdata, err=0.
  - On acceptance, a read clears the counter and goes to WAIT_RD.
- WAIT_RD: mem_req=0.
  - If mem_rvalid: resp_data=mem_rdata, err=0, go to RESP.
  - Otherwise increment the counter. When counter reaches TIMEOUT-1 without mem_rvalid: resp_data=0, err=1, go to RESP.
  - mem_rvalid and timeout in the same cycle: data wins, err=0.
- RESP: rvalid[owner]=1, rdata[owner]=resp_data, err[owner] as captured, all for one cycle. Set rr_ptr=(owner+1) mod 3. Go to IDLE.

Rules and boundary conditions:
- Latency with mem_ready tied 1:
  - Write: req seen cycle N, gnt N+1, mem_req N+1, rvalid N+2.
  - Read: rvalid one cycle after mem_rvalid.
- Requester contract: hold req/we/addr/wdata until gnt. Drop req in the gnt cycle or re-request. A new req is sampled only in IDLE, so the next grant comes at earliest one cycle after RESP.
- Only one transaction is outstanding. Requests arriving during a transaction wait and are never lost.
- mem_rvalid outside WAIT_RD is ignored.
- Simultaneous requests: rotation guarantees each requesting core is served within 3 transactions.
- Reset mid-transaction: all outputs go to 0 immediately. The in-flight transaction is dropped with no response, and rr_ptr returns to 0.
- Invariants: gnt, rvalid, err each one-hot or zero. err is never set without rvalid.

Decomposition:
- Package mp_pkg:
  - NCORES=3
  - core_id_t (2-bit)
  - arb_state_t enum {IDLE, ISSUE, WAIT_RD, RESP}
  - function next_ptr (mod-3 increment)
- Sub-module rr_pick: combinational 3-way round-robin picker. Inputs: req[2:0], ptr. Outputs: valid, winner id. Unit-testable on its own.

Test Plan:
1. Single write, mem_ready=1: core1 req, we=1, addr=0x005, wdata=0xA5 at cycle N -> gnt=3'b010 at N+1, mem_req with addr=0x005 and mem_wdata=0xA5 at N+1, rvalid=3'b010 and rdata[1]=0xA5 at N+2, busy high N+1..N+2.
2. Read with 3-cycle memory latency: core2 reads 0x010, mem_rdata=0x3C returned 3 cycles after acceptance -> rvalid[2]=1, rdata[2]=0x3C, err=0. The other cores' rdata stay 0.
3. All three cores request continuously from reset, writes -> grant order 0,1,2,0,1,2. Each gnt is one-hot, and gnt occurs every 3 cycles.
4. mem_ready held 0 for 5 cycles during ISSUE -> mem_req and fields stable for those 5 cycles, no rvalid; completes normally after mem_ready=1.
5. Read with mem_rvalid never asserted, TIMEOUT=16 -> after 16 cycles in WAIT_RD: rvalid[owner]=1, err[owner]=1, rdata=0. The next request is then serviced normally.
6. Assert rst_n=0 during WAIT_RD, release, then apply a stray mem_rvalid -> all outputs 0, no rvalid, the stray mem_rvalid is ignored, and the next grant goes to core0 when all cores request.
